// File: rtl/hi_lo_unit.sv
// hi_lo_unit: architectural HI/LO register pair with MULT/MADD/MSUB/MTHI/MTLO
// writes, MFHI/MFLO reads, and a one-cycle accumulate pipeline that stalls
// any HI/LO access which would race an in-flight accumulation.
module hi_lo_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        OpValid,
    input  logic [2:0]  HiLoOp,
    input  logic [63:0] ProductIn,
    input  logic [31:0] RsData,
    input  logic        ReadEn,
    input  logic        ReadSel,
    output logic [31:0] ReadData,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Stall,
    output logic        Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_WRITE64 = 3'b001,
        OP_MADD    = 3'b010,
        OP_MSUB    = 3'b011,
        OP_MTHI    = 3'b100,
        OP_MTLO    = 3'b101
    } op_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] hi;
    logic [31:0] hi_next;
    logic [31:0] lo;
    logic [31:0] lo_next;
    logic [63:0] acc_prod;
    logic [63:0] acc_prod_next;
    logic        acc_sub;
    logic        acc_sub_next;
    logic        op_active;
    logic        accept;
    logic [63:0] acc_result;

    assign op_active = OpValid && (HiLoOp != OP_NOP) && (HiLoOp <= OP_MTLO);
    assign Busy      = (state == ACC);
    assign Stall     = Busy && (op_active || ReadEn);
    assign accept    = op_active && !Stall;
    assign acc_result = acc_sub ? ({hi, lo} - acc_prod) : ({hi, lo} + acc_prod);
    assign ReadData  = ReadSel ? hi : lo;
    assign Hi        = hi;
    assign Lo        = lo;

    // Next-state and next-register values; any active op in ACC is stalled.
    always_comb begin
        state_next    = state;
        hi_next       = hi;
        lo_next       = lo;
        acc_prod_next = acc_prod;
        acc_sub_next  = acc_sub;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (HiLoOp)
                        OP_WRITE64: {hi_next, lo_next} = ProductIn;
                        OP_MADD, OP_MSUB: begin
                            acc_prod_next = ProductIn;
                            acc_sub_next  = (HiLoOp == OP_MSUB);
                            state_next    = ACC;
                        end
                        OP_MTHI: hi_next = RsData;
                        OP_MTLO: lo_next = RsData;
                        default: ;
                    endcase
                end
            end
            ACC: begin
                {hi_next, lo_next} = acc_result;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and register update; synchronous reset discards any pending accumulation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            acc_prod <= '0;
            acc_sub  <= 1'b0;
        end else begin
            state    <= state_next;
            hi       <= hi_next;
            lo       <= lo_next;
            acc_prod <= acc_prod_next;
            acc_sub  <= acc_sub_next;
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit: directed-vector bench for hi_lo_unit with hand-computed
// expected values for writes, accumulation, stalls, reads and reset.
module tb_hi_lo_unit;

    logic        Clk;
    logic        Reset;
    logic        OpValid;
    logic [2:0]  HiLoOp;
    logic [63:0] ProductIn;
    logic [31:0] RsData;
    logic        ReadEn;
    logic        ReadSel;
    logic [31:0] ReadData;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Stall;
    logic        Busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    hi_lo_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .OpValid   (OpValid),
        .HiLoOp    (HiLoOp),
        .ProductIn (ProductIn),
        .RsData    (RsData),
        .ReadEn    (ReadEn),
        .ReadSel   (ReadSel),
        .ReadData  (ReadData),
        .Hi        (Hi),
        .Lo        (Lo),
        .Stall     (Stall),
        .Busy      (Busy)
    );

    // Free-running 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        OpValid = 1'b0;
        HiLoOp  = 3'b000;
        ReadEn  = 1'b0;
        ReadSel = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] prod, input logic [31:0] rs);
        OpValid   = 1'b1;
        HiLoOp    = op;
        ProductIn = prod;
        RsData    = rs;
    endtask

    // Directed stimulus; inputs change 1 ns after the rising edge, checks follow 1 ns later.
    initial begin
        Reset     = 1'b1;
        ProductIn = '0;
        RsData    = '0;
        idle_inputs();
        tick();
        tick();
        #1;
        check("rst_hi", {32'h0, Hi}, 64'h0);
        check("rst_lo", {32'h0, Lo}, 64'h0);
        check("rst_rdata", {32'h0, ReadData}, 64'h0);
        check("rst_busy", {63'h0, Busy}, 64'h0);
        check("rst_stall", {63'h0, Stall}, 64'h0);
        Reset = 1'b0;

        // WRITE64 then MFLO
        issue(3'b001, 64'h0000_0001_FFFF_FFFE, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("w64_hi", {32'h0, Hi}, 64'h1);
        check("w64_lo", {32'h0, Lo}, 64'hFFFF_FFFE);
        ReadEn = 1'b1; ReadSel = 1'b0;
        #1;
        check("w64_mflo", {32'h0, ReadData}, 64'hFFFF_FFFE);
        ReadSel = 1'b1;
        #1;
        check("w64_mfhi", {32'h0, ReadData}, 64'h1);
        idle_inputs();

        // MADD with carry from LO into HI; ProductIn changes during ACC must not matter
        issue(3'b001, 64'h0000_0000_FFFF_FFFF, 32'h0);
        tick();
        issue(3'b010, 64'h1, 32'h0);
        tick();
        idle_inputs();
        ProductIn = 64'h1234_0000_0000_0000;
        #1;
        check("madd_busy", {63'h0, Busy}, 64'h1);
        check("madd_hi_pending", {32'h0, Hi}, 64'h0);
        tick();
        check("madd_busy_clr", {63'h0, Busy}, 64'h0);
        check("madd_hilo", {Hi, Lo}, 64'h0000_0001_0000_0000);

        // MSUB wrap below zero
        issue(3'b001, 64'h0, 32'h0);
        tick();
        issue(3'b011, 64'h5, 32'h0);
        tick();
        idle_inputs();
        tick();
        check("msub_wrap", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFB);

        // Back-to-back MADD: second one stalls exactly one cycle
        issue(3'b001, 64'h0, 32'h0);
        tick();
        issue(3'b010, 64'h3, 32'h0);          // cycle 1: accepted
        #1;
        check("b2b_c1_stall", {63'h0, Stall}, 64'h0);
        tick();                               // cycle 2: held, stalled
        #1;
        check("b2b_c2_stall", {63'h0, Stall}, 64'h1);
        tick();                               // cycle 3: accepted
        #1;
        check("b2b_c3_stall", {63'h0, Stall}, 64'h0);
        check("b2b_c3_hilo", {Hi, Lo}, 64'h3);
        tick();                               // cycle 4
        idle_inputs();
        #1;
        check("b2b_c4_busy", {63'h0, Busy}, 64'h1);
        tick();                               // cycle 5
        check("b2b_c5_hilo", {Hi, Lo}, 64'h6);

        // MADD then MFHI the next cycle
        issue(3'b010, 64'h0000_0005_0000_0000, 32'h0);
        tick();
        idle_inputs();
        ReadEn = 1'b1; ReadSel = 1'b1;
        #1;
        check("mfhi_stall", {63'h0, Stall}, 64'h1);
        tick();
        check("mfhi_stall_clr", {63'h0, Stall}, 64'h0);
        check("mfhi_data", {32'h0, ReadData}, 64'h5);

        // MTLO with same-cycle MFLO returns old LO
        issue(3'b101, 64'h0, 32'h1234_5678);
        ReadEn = 1'b1; ReadSel = 1'b0;
        #1;
        check("mtlo_old_read", {32'h0, ReadData}, 64'h6);
        tick();
        idle_inputs();
        check("mtlo_lo", {32'h0, Lo}, 64'h1234_5678);
        check("mtlo_hi_kept", {32'h0, Hi}, 64'h5);

        // MTHI leaves LO untouched
        issue(3'b100, 64'h0, 32'hAABB_CCDD);
        tick();
        idle_inputs();
        check("mthi_hilo", {Hi, Lo}, 64'hAABB_CCDD_1234_5678);

        // Reset during ACC discards the accumulation
        issue(3'b010, 64'h7, 32'h0);
        tick();
        idle_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_acc_hilo", {Hi, Lo}, 64'h0);
        check("rst_acc_busy", {63'h0, Busy}, 64'h0);
        tick();
        check("rst_acc_after", {Hi, Lo}, 64'h0);

        // Reserved opcode in IDLE: no effect, no stall
        issue(3'b111, 64'hDEAD_BEEF_DEAD_BEEF, 32'hCAFE_F00D);
        #1;
        check("rsv_idle_stall", {63'h0, Stall}, 64'h0);
        tick();
        idle_inputs();
        check("rsv_idle_hilo", {Hi, Lo}, 64'h0);
        check("rsv_idle_busy", {63'h0, Busy}, 64'h0);

        // Reserved opcode and NOP during ACC do not stall
        issue(3'b010, 64'h1, 32'h0);
        tick();
        issue(3'b110, 64'h0, 32'h0);
        #1;
        check("rsv_acc_stall", {63'h0, Stall}, 64'h0);
        HiLoOp = 3'b000;
        #1;
        check("nop_acc_stall", {63'h0, Stall}, 64'h0);
        tick();
        idle_inputs();
        check("rsv_acc_hilo", {Hi, Lo}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
